// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiplier FSM states, datapath width.
package ex_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ex_state_e;

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_RADIX multiplier bits per step.
// Only the low XLEN bits of the product are kept, which is all the pipeline writes back.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int STEPS = XLEN / MUL_RADIX;
    localparam int CNT_W = $clog2(STEPS);

    logic [XLEN-1:0]  mcand;
    logic [XLEN-1:0]  mplier;
    logic [XLEN-1:0]  acc;
    logic [XLEN-1:0]  partial;
    logic [CNT_W-1:0] count;
    logic             running;

    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_RADIX; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    // done marks the final step; the accumulator is complete one edge later
    assign done    = running && (count == CNT_W'(STEPS - 1));
    assign product = acc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (kill) begin
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= op_a;
            mplier  <= op_b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_RADIX;
            mplier <= mplier >> MUL_RADIX;
            count  <= count + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, iterative multiply and the EX/MEM register.
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     pc_i,
    input  logic [XLEN-1:0] rr_data1_i,
    input  logic [XLEN-1:0] rr_data2_i,
    input  logic [XLEN-1:0] se_immed_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic            regwrite_i,
    input  logic            memread_i,
    input  logic            memwrite_i,
    input  logic            memtoreg_i,
    input  logic            alusrc_i,
    input  logic            branch_i,
    input  logic            jump_i,
    input  logic [3:0]      alu_control_i,
    input  logic            ctrl_r_i,
    input  logic            memwb_regwrite_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic [XLEN-1:0] memwb_data_i,
    input  logic            ex_kill_i,
    input  logic            ex_mem_lock_i,
    input  logic            ex_mem_flush_i,
    output logic            ex_busy_o,
    output logic            branch_taken_o,
    output logic [31:0]     branch_target_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_o,
    output logic            regwrite_o,
    output logic            memread_o,
    output logic            memwrite_o,
    output logic            memtoreg_o
);

    ex_state_e       state;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] ex_result;
    logic [XLEN-1:0] mul_product;
    logic            mul_done;
    logic            mul_start;
    logic            mul_kill;
    logic            is_mul;

    // A load sitting in EX/MEM has no data yet, so it never forwards from there
    always_comb begin
        fwd_a = rr_data1_i;
        if (regwrite_o && !memread_o && rd_o != 5'd0 && rd_o == rs1_i) begin
            fwd_a = alu_result_o;
        end else if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs1_i) begin
            fwd_a = memwb_data_i;
        end
        fwd_b = rr_data2_i;
        if (regwrite_o && !memread_o && rd_o != 5'd0 && rd_o == rs2_i) begin
            fwd_b = alu_result_o;
        end else if (memwb_regwrite_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs2_i) begin
            fwd_b = memwb_data_i;
        end
    end

    assign op_b   = alusrc_i ? se_immed_i : fwd_b;
    assign is_mul = ctrl_r_i && (alu_control_i == ALU_MUL);

    // MUL code without the R-type flag degrades to ADD; the real product comes from ex_mul_iter
    always_comb begin
        alu_out = '0;
        case (alu_control_i)
            ALU_AND: alu_out = fwd_a & op_b;
            ALU_OR:  alu_out = fwd_a | op_b;
            ALU_ADD: alu_out = fwd_a + op_b;
            ALU_XOR: alu_out = fwd_a ^ op_b;
            ALU_SLL: alu_out = fwd_a << op_b[5:0];
            ALU_SRL: alu_out = fwd_a >> op_b[5:0];
            ALU_SUB: alu_out = fwd_a - op_b;
            ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
            ALU_MUL: alu_out = fwd_a + op_b;
            default: alu_out = '0;
        endcase
    end

    assign branch_taken_o  = (state == ST_IDLE) && !ex_kill_i &&
                             (jump_i || (branch_i && (fwd_a == fwd_b)));
    assign branch_target_o = pc_i + {se_immed_i[30:0], 1'b0};

    assign ex_result = (state == ST_DONE) ? mul_product :
                       jump_i             ? {{(XLEN-32){1'b0}}, pc_i + 32'd4} :
                                            alu_out;

    always_comb begin
        ex_busy_o = 1'b0;
        case (state)
            ST_IDLE: ex_busy_o = is_mul && !ex_kill_i;
            ST_RUN:  ex_busy_o = 1'b1;
            ST_DONE: ex_busy_o = ex_mem_lock_i;
            default: ex_busy_o = 1'b0;
        endcase
    end

    assign mul_start = (state == ST_IDLE) && is_mul && !ex_kill_i;
    assign mul_kill  = ex_kill_i && (state != ST_IDLE);

    ex_mul_iter #(
        .XLEN      (XLEN),
        .MUL_RADIX (MUL_RADIX)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (mul_start),
        .kill    (mul_kill),
        .op_a    (fwd_a),
        .op_b    (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // DONE is left only once EX/MEM can accept the product, so it never drops under a lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (mul_start) state <= ST_RUN;
                ST_RUN: begin
                    if (ex_kill_i) begin
                        state <= ST_IDLE;
                    end else if (mul_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: if (ex_kill_i || !ex_mem_lock_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_result_o <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
            regwrite_o   <= 1'b0;
            memread_o    <= 1'b0;
            memwrite_o   <= 1'b0;
            memtoreg_o   <= 1'b0;
        end else if (ex_mem_flush_i || (!ex_mem_lock_i && (ex_busy_o || ex_kill_i))) begin
            alu_result_o <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
            regwrite_o   <= 1'b0;
            memread_o    <= 1'b0;
            memwrite_o   <= 1'b0;
            memtoreg_o   <= 1'b0;
        end else if (!ex_mem_lock_i) begin
            alu_result_o <= ex_result;
            store_data_o <= fwd_b;
            rd_o         <= rd_i;
            regwrite_o   <= regwrite_i;
            memread_o    <= memread_i;
            memwrite_o   <= memwrite_i;
            memtoreg_o   <= memtoreg_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vector table plus forwarding, branch and multiplier sequences.
module tb_ex_stage;

    localparam int XLEN      = 64;
    localparam int MUL_RADIX = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [63:0] rr_data1, rr_data2, se_immed;
    logic [4:0]  rd, rs1, rs2;
    logic        regwrite, memread, memwrite, memtoreg, alusrc, branch, jump;
    logic [3:0]  alu_control;
    logic        ctrl_r;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [63:0] memwb_data;
    logic        ex_kill, ex_mem_lock, ex_mem_flush;
    logic        ex_busy, branch_taken;
    logic [31:0] branch_target;
    logic [63:0] alu_result, store_data;
    logic [4:0]  rd_out;
    logic        regwrite_out, memread_out, memwrite_out, memtoreg_out;
    logic [8:0]  ctrl_out;

    assign ctrl_out = {rd_out, regwrite_out, memread_out, memwrite_out, memtoreg_out};

    always #5 clk = ~clk;

    ex_stage #(.XLEN(XLEN), .MUL_RADIX(MUL_RADIX)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pc_i             (pc),
        .rr_data1_i       (rr_data1),
        .rr_data2_i       (rr_data2),
        .se_immed_i       (se_immed),
        .rd_i             (rd),
        .rs1_i            (rs1),
        .rs2_i            (rs2),
        .regwrite_i       (regwrite),
        .memread_i        (memread),
        .memwrite_i       (memwrite),
        .memtoreg_i       (memtoreg),
        .alusrc_i         (alusrc),
        .branch_i         (branch),
        .jump_i           (jump),
        .alu_control_i    (alu_control),
        .ctrl_r_i         (ctrl_r),
        .memwb_regwrite_i (memwb_regwrite),
        .memwb_rd_i       (memwb_rd),
        .memwb_data_i     (memwb_data),
        .ex_kill_i        (ex_kill),
        .ex_mem_lock_i    (ex_mem_lock),
        .ex_mem_flush_i   (ex_mem_flush),
        .ex_busy_o        (ex_busy),
        .branch_taken_o   (branch_taken),
        .branch_target_o  (branch_target),
        .alu_result_o     (alu_result),
        .store_data_o     (store_data),
        .rd_o             (rd_out),
        .regwrite_o       (regwrite_out),
        .memread_o        (memread_out),
        .memwrite_o       (memwrite_out),
        .memtoreg_o       (memtoreg_out)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic        ctrl_r;
        logic        alusrc;
        logic        branch;
        logic        jump;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] imm;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic [63:0] exp_result;
        logic [63:0] exp_store;
    } vec_t;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] store;
        logic [8:0]  ctrl;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[14];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic vec_t alu_vec(input logic [3:0] op, input logic cr, input logic src,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] imm, input logic [63:0] res);
        vec_t v;
        v            = '0;
        v.op         = op;
        v.ctrl_r     = cr;
        v.alusrc     = src;
        v.rs1        = 5'd1;
        v.rs2        = 5'd2;
        v.rd         = 5'd10;
        v.a          = a;
        v.b          = b;
        v.imm        = imm;
        v.regwrite   = 1'b1;
        v.exp_result = res;
        v.exp_store  = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp_v);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit push);
        exp_t e;
        alu_control = v.op;
        ctrl_r      = v.ctrl_r;
        alusrc      = v.alusrc;
        branch      = v.branch;
        jump        = v.jump;
        rs1         = v.rs1;
        rs2         = v.rs2;
        rd          = v.rd;
        pc          = v.pc;
        rr_data1    = v.a;
        rr_data2    = v.b;
        se_immed    = v.imm;
        regwrite    = v.regwrite;
        memread     = v.memread;
        memwrite    = v.memwrite;
        memtoreg    = v.memtoreg;
        if (push) begin
            e.result = v.exp_result;
            e.store  = v.exp_store;
            e.ctrl   = {v.rd, v.regwrite, v.memread, v.memwrite, v.memtoreg};
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: got result 0x%h with no queued expectation", name, alu_result);
        end else begin
            e = sb.pop_front();
            check({name, "_result"}, alu_result, e.result);
            check({name, "_store"}, store_data, e.store);
            check({name, "_ctrl"}, 64'(ctrl_out), 64'(e.ctrl));
        end
    endtask

    task automatic checkBubble(input string name);
        check({name, "_result"}, alu_result, 64'h0);
        check({name, "_ctrl"}, 64'(ctrl_out), 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   busy_cycles;
        bit   done_seen;

        vecs[0]  = alu_vec(4'b0000, 1'b0, 1'b0, 64'hF0F0, 64'hFF00, 64'h0, 64'hF000);
        vecs[1]  = alu_vec(4'b0001, 1'b0, 1'b0, 64'hF0F0, 64'h0F0F, 64'h0, 64'hFFFF);
        vecs[2]  = alu_vec(4'b0010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h0);
        vecs[3]  = alu_vec(4'b0011, 1'b0, 1'b0, 64'hAAAA, 64'hFFFF, 64'h0, 64'h5555);
        vecs[4]  = alu_vec(4'b0100, 1'b0, 1'b0, 64'h1, 64'd63, 64'h0, 64'h8000_0000_0000_0000);
        vecs[5]  = alu_vec(4'b0100, 1'b0, 1'b0, 64'h1, 64'h41, 64'h0, 64'h2);
        vecs[6]  = alu_vec(4'b0101, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'h0,
                           64'h0800_0000_0000_0000);
        vecs[7]  = alu_vec(4'b0110, 1'b0, 1'b0, 64'd3, 64'd5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
        vecs[8]  = alu_vec(4'b0111, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h1);
        vecs[9]  = alu_vec(4'b0111, 1'b0, 1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0);
        vecs[10] = alu_vec(4'b1000, 1'b0, 1'b0, 64'd2, 64'd3, 64'h0, 64'd5);
        vecs[11] = alu_vec(4'b1001, 1'b0, 1'b0, 64'd7, 64'd9, 64'h0, 64'h0);
        vecs[12] = alu_vec(4'b0010, 1'b0, 1'b1, 64'd10, 64'd100, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7);
        vecs[12].regwrite = 1'b0;
        vecs[12].memwrite = 1'b1;
        vecs[13] = alu_vec(4'b0101, 1'b0, 1'b0, 64'h1234, 64'h40, 64'h0, 64'h1234);

        rst            = 1'b1;
        ex_kill        = 1'b0;
        ex_mem_lock    = 1'b0;
        ex_mem_flush   = 1'b0;
        memwb_regwrite = 1'b0;
        memwb_rd       = 5'd0;
        memwb_data     = 64'h0;
        applyStimulus('0, 1'b0);
        #2;
        check("reset_result", alu_result, 64'h0);
        check("reset_store", store_data, 64'h0);
        check("reset_ctrl", 64'(ctrl_out), 64'h0);
        check("reset_busy", 64'(ex_busy), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 1'b1);
            tick();
            checkOutput($sformatf("vec%0d", i));
        end

        // Forwarding priority and exclusions
        applyStimulus(alu_vec(4'b0010, 1'b0, 1'b0, 64'd2, 64'd3, 64'h0, 64'd5), 1'b0);
        rd = 5'd3;
        sb.push_back('{64'd5, 64'd3, {5'd3, 4'b1000}});
        tick();
        checkOutput("fwd_setup");

        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'hDEAD, 64'd2, 64'h0, 64'd7);
        v.rs1 = 5'd3; v.rs2 = 5'd4; v.rd = 5'd8;
        memwb_regwrite = 1'b1; memwb_rd = 5'd3; memwb_data = 64'd9;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("fwd_exmem");

        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd1, 64'd1, 64'h0, 64'd18);
        v.rs1 = 5'd3; v.rs2 = 5'd3; v.rd = 5'd8; v.exp_store = 64'd9;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("fwd_memwb");

        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd7, 64'd1, 64'h0, 64'd8);
        v.rd = 5'd5; v.memread = 1'b1; v.memtoreg = 1'b1;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("load_setup");

        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd1, 64'd2, 64'h0, 64'd22);
        v.rs1 = 5'd5; v.rs2 = 5'd6;
        memwb_rd = 5'd5; memwb_data = 64'd20;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("fwd_load_blocked");

        memwb_regwrite = 1'b0;
        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd100, 64'd1, 64'h0, 64'd101);
        v.rd = 5'd0;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("x0_setup");

        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd4, 64'd5, 64'h0, 64'd9);
        v.rs1 = 5'd0; v.rs2 = 5'd0;
        memwb_regwrite = 1'b1; memwb_rd = 5'd0; memwb_data = 64'd50;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("fwd_x0");
        memwb_regwrite = 1'b0;

        // Branches and jumps
        v = '0;
        v.op = 4'b0110; v.branch = 1'b1; v.rs1 = 5'd1; v.rs2 = 5'd2;
        v.a = 64'h10; v.b = 64'h10; v.pc = 32'h100; v.imm = 64'd8;
        v.exp_result = 64'h0; v.exp_store = 64'h10;
        applyStimulus(v, 1'b1);
        #1;
        check("beq_taken", 64'(branch_taken), 64'h1);
        check("beq_target", 64'(branch_target), 64'h110);
        tick();
        checkOutput("beq");

        v.b = 64'h11; v.exp_result = 64'hFFFF_FFFF_FFFF_FFFF; v.exp_store = 64'h11;
        applyStimulus(v, 1'b1);
        #1;
        check("bne_not_taken", 64'(branch_taken), 64'h0);
        tick();
        checkOutput("bne");

        v = '0;
        v.op = 4'b0010; v.jump = 1'b1; v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd1;
        v.regwrite = 1'b1; v.pc = 32'h200; v.imm = 64'h10; v.exp_result = 64'h204;
        applyStimulus(v, 1'b1);
        #1;
        check("jal_taken", 64'(branch_taken), 64'h1);
        check("jal_target", 64'(branch_target), 64'h220);
        tick();
        checkOutput("jal");

        v = '0;
        v.op = 4'b0110; v.branch = 1'b1; v.rs1 = 5'd1; v.rs2 = 5'd2; v.a = 64'h5; v.b = 64'h5;
        v.regwrite = 1'b1; v.rd = 5'd4;
        applyStimulus(v, 1'b0);
        ex_kill = 1'b1;
        #1;
        check("kill_no_branch", 64'(branch_taken), 64'h0);
        tick();
        ex_kill = 1'b0;
        checkBubble("kill_bubble");

        applyStimulus(alu_vec(4'b0010, 1'b0, 1'b0, 64'd4, 64'd4, 64'h0, 64'd8), 1'b0);
        ex_mem_flush = 1'b1;
        tick();
        ex_mem_flush = 1'b0;
        checkBubble("flush");

        // Full multiply, radix 1: 65 busy cycles then the product
        v = alu_vec(4'b1000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h0,
                    64'hFFFF_FFFF_FFFF_FFFD);
        v.rd = 5'd7;
        applyStimulus(v, 1'b1);
        #1;
        busy_cycles = ex_busy ? 1 : 0;
        done_seen   = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (!ex_busy) begin
                done_seen = 1'b1;
                break;
            end
            busy_cycles++;
        end
        check("mul_busy_drop", 64'(done_seen), 64'h1);
        check("mul_busy_cycles", 64'(busy_cycles), 64'd65);
        checkBubble("mul_pending");
        tick();
        checkOutput("mul_product");
        applyStimulus('0, 1'b0);

        // Kill during RUN cycle 10
        v = alu_vec(4'b1000, 1'b1, 1'b0, 64'd5, 64'd7, 64'h0, 64'd35);
        v.rd = 5'd9;
        applyStimulus(v, 1'b0);
        repeat (10) tick();
        ex_kill = 1'b1;
        tick();
        ex_kill = 1'b0;
        applyStimulus(alu_vec(4'b0010, 1'b0, 1'b0, 64'd4, 64'd4, 64'h0, 64'd8), 1'b1);
        #1;
        check("kill_busy_drop", 64'(ex_busy), 64'h0);
        checkBubble("kill_exmem");
        tick();
        checkOutput("after_kill_add");

        // EX/MEM lock held through the first three DONE cycles
        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd10, 64'd11, 64'h0, 64'd21);
        v.rd = 5'd12;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("lock_setup");
        v = alu_vec(4'b1000, 1'b1, 1'b0, 64'd6, 64'd7, 64'h0, 64'd42);
        v.rd = 5'd4;
        applyStimulus(v, 1'b1);
        ex_mem_lock = 1'b1;
        repeat (65) tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lock_busy%0d", k), 64'(ex_busy), 64'h1);
            check($sformatf("lock_hold%0d", k), alu_result, 64'd21);
            tick();
        end
        ex_mem_lock = 1'b0;
        #1;
        check("lock_release_busy", 64'(ex_busy), 64'h0);
        tick();
        checkOutput("lock_product");
        applyStimulus('0, 1'b0);

        // Asynchronous reset in the middle of a multiply
        v = alu_vec(4'b0010, 1'b0, 1'b0, 64'd1, 64'd2, 64'h0, 64'd3);
        v.rd = 5'd2;
        applyStimulus(v, 1'b1);
        tick();
        checkOutput("rst_setup");
        v = alu_vec(4'b1000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h1);
        v.rd = 5'd6;
        applyStimulus(v, 1'b0);
        ex_mem_lock = 1'b1;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        applyStimulus('0, 1'b0);
        ex_mem_lock = 1'b0;
        #1;
        check("rst_mid_result", alu_result, 64'h0);
        check("rst_mid_store", store_data, 64'h0);
        check("rst_mid_ctrl", 64'(ctrl_out), 64'h0);
        check("rst_mid_busy", 64'(ex_busy), 64'h0);
        #2;
        rst = 1'b0;
        tick();
        applyStimulus(alu_vec(4'b0010, 1'b0, 1'b0, 64'd1, 64'd1, 64'h0, 64'd2), 1'b1);
        #1;
        check("rst_add_busy", 64'(ex_busy), 64'h0);
        tick();
        checkOutput("rst_add");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
